// File: rtl/register_unit_pkg.sv
// Shared types for the register unit: shift modes and sequencer states.
package register_unit_pkg;

  typedef enum logic [1:0] {
    LSR = 2'b00,
    ASR = 2'b01,
    ROR = 2'b10,
    LSL = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_reg_n.sv
// WIDTH-bit shift register with parallel load, bidirectional 1-bit shift
// and serial taps at both ends.
module shift_reg_n #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ld_i,
  input  logic             shift_i,
  input  logic             left_i,
  input  logic             ser_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             lsb_o,
  output logic             msb_o
);

  logic [WIDTH-1:0] q_q, q_d;

  // Next value: load has priority; otherwise shift toward MSB (left) or LSB.
  always_comb begin
    q_d = q_q;
    if (ld_i) begin
      q_d = d_i;
    end else if (shift_i) begin
      if (left_i) q_d = {q_q[WIDTH-2:0], ser_i};
      else        q_d = {ser_i, q_q[WIDTH-1:1]};
    end
  end

  // Register with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o   = q_q;
  assign lsb_o = q_q[0];
  assign msb_o = q_q[WIDTH-1];

endmodule

// File: rtl/register_unit_n.sv
// Two-register {A,B} shift datapath with a counted shift sequencer and a
// Start/Busy/Done handshake.
module register_unit_n
  import register_unit_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CW    = $clog2(2*WIDTH+1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Ld_A,
  input  logic             Ld_B,
  input  logic [WIDTH-1:0] D,
  input  logic             Start,
  input  logic [CW-1:0]    Shift_Count,
  input  logic [1:0]       Mode,
  input  logic             A_In,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             A_out,
  output logic             B_out,
  output logic             Busy,
  output logic             Done
);

  localparam logic [CW-1:0] MAX_COUNT = CW'(2*WIDTH);

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  shift_mode_t mode_q, mode_d;
  logic        ain_q, ain_d;

  logic        shift_en;
  logic        load_ok;
  logic        left;
  logic        a_ser, b_ser;
  logic        a_lsb, a_msb, b_lsb, b_msb;
  logic [CW-1:0] count_clamped;

  assign count_clamped = (Shift_Count > MAX_COUNT) ? MAX_COUNT : Shift_Count;
  assign load_ok       = (state_q != SHIFT);
  assign left          = (mode_q == LSL);

  // Sequencer next-state: latch operation at Start, count down while shifting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    ain_d    = ain_q;
    shift_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          mode_d  = shift_mode_t'(Mode);
          ain_d   = A_In;
          cnt_d   = count_clamped;
          state_d = (count_clamped == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and latched operation parameters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= LSR;
      ain_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      ain_q   <= ain_d;
    end
  end

  // Serial links between A and B for the latched mode.
  always_comb begin
    a_ser = ain_q;
    b_ser = a_lsb;
    unique case (mode_q)
      LSR: begin a_ser = ain_q; b_ser = a_lsb; end
      ASR: begin a_ser = a_msb; b_ser = a_lsb; end
      ROR: begin a_ser = b_lsb; b_ser = a_lsb; end
      LSL: begin a_ser = b_msb; b_ser = ain_q; end
      default: begin a_ser = ain_q; b_ser = a_lsb; end
    endcase
  end

  shift_reg_n #(.WIDTH(WIDTH)) reg_A (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .ld_i    (Ld_A && load_ok),
    .shift_i (shift_en),
    .left_i  (left),
    .ser_i   (a_ser),
    .d_i     (D),
    .q_o     (A),
    .lsb_o   (a_lsb),
    .msb_o   (a_msb)
  );

  shift_reg_n #(.WIDTH(WIDTH)) reg_B (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .ld_i    (Ld_B && load_ok),
    .shift_i (shift_en),
    .left_i  (left),
    .ser_i   (b_ser),
    .d_i     (D),
    .q_o     (B),
    .lsb_o   (b_lsb),
    .msb_o   (b_msb)
  );

  assign A_out = a_lsb;
  assign B_out = b_lsb;
  assign Busy  = (state_q == SHIFT);
  assign Done  = (state_q == DONE);

endmodule

// File: tb/tb_register_unit_n.sv
// Directed bench for register_unit_n at WIDTH=8.
module tb_register_unit_n;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(2*W+1);

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Ld_A, Ld_B, Start, A_In;
  logic [W-1:0]  D;
  logic [CW-1:0] Shift_Count;
  logic [1:0]    Mode;
  logic [W-1:0]  A, B;
  logic          A_out, B_out, Busy, Done;

  int errors = 0;
  int checks = 0;

  register_unit_n #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Ld_A(Ld_A), .Ld_B(Ld_B), .D(D),
    .Start(Start), .Shift_Count(Shift_Count), .Mode(Mode), .A_In(A_In),
    .A(A), .B(B), .A_out(A_out), .B_out(B_out), .Busy(Busy), .Done(Done)
  );

  initial forever #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    Ld_A = 1'b1; D = a; step();
    Ld_A = 1'b0; Ld_B = 1'b1; D = b; step();
    Ld_B = 1'b0;
  endtask

  // Drive Start for one edge (E0).
  task automatic start(input logic [1:0] m, input logic ain, input int cnt);
    Mode = m; A_In = ain; Shift_Count = CW'(cnt); Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  // Count Busy cycles from now until Busy drops, bounded.
  task automatic wait_idle_busy(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
  endtask

  task automatic check_result(input string tag, input int nbusy, input int exp_n,
                              input logic [W-1:0] ea, input logic [W-1:0] eb);
    chk({tag, "_busy_cycles"}, nbusy, exp_n);
    chk({tag, "_done"}, Done, 1'b1);
    chk({tag, "_A"}, A, ea);
    chk({tag, "_B"}, B, eb);
    chk({tag, "_A_out"}, A_out, ea[0]);
    chk({tag, "_B_out"}, B_out, eb[0]);
    step();
    chk({tag, "_done_drop"}, Done, 1'b0);
  endtask

  initial begin
    int n;
    Reset = 1'b1; Ld_A = 0; Ld_B = 0; Start = 0; A_In = 0;
    D = '0; Shift_Count = '0; Mode = 2'b00;
    #2;
    chk("rst_A", A, 8'h00);
    chk("rst_B", B, 8'h00);
    chk("rst_Busy", Busy, 1'b0);
    chk("rst_Done", Done, 1'b0);
    chk("rst_A_out", A_out, 1'b0);
    step(); step();
    Reset = 1'b0;
    step();

    load(8'h96, 8'h3C);
    chk("load_A", A, 8'h96);
    chk("load_B", B, 8'h3C);

    // LSR count 4
    start(2'b00, 1'b0, 4);
    chk("lsr_busy_after_E0", Busy, 1'b1);
    wait_idle_busy(n);
    check_result("lsr4", n, 4, 8'h09, 8'h63);

    // ASR count 4
    load(8'h96, 8'h3C);
    start(2'b01, 1'b0, 4);
    wait_idle_busy(n);
    check_result("asr4", n, 4, 8'hF9, 8'h63);

    // ROR full rotation and clamped count
    load(8'h96, 8'h3C);
    start(2'b10, 1'b0, 16);
    wait_idle_busy(n);
    check_result("ror16", n, 16, 8'h96, 8'h3C);
    start(2'b10, 1'b0, 20);
    wait_idle_busy(n);
    check_result("ror20_clamp", n, 16, 8'h96, 8'h3C);

    // LSL count 3 with ignored mid-shift load, Start and input changes
    load(8'h96, 8'h3C);
    start(2'b11, 1'b1, 3);
    Ld_A = 1'b1; D = 8'h00; Start = 1'b1; Mode = 2'b00; A_In = 1'b0;
    step();
    Ld_A = 1'b0; Start = 1'b0;
    wait_idle_busy(n);
    check_result("lsl3_mid", n + 1, 3, 8'hB1, 8'hE7);
    chk("lsl3_no_queue_busy", Busy, 1'b0);
    step();
    chk("lsl3_no_queue_busy2", Busy, 1'b0);
    chk("lsl3_no_queue_done", Done, 1'b0);

    // Count 0: immediate Done, no shift
    load(8'h96, 8'h3C);
    start(2'b00, 1'b0, 0);
    chk("cnt0_busy", Busy, 1'b0);
    check_result("cnt0", 0, 0, 8'h96, 8'h3C);

    // Start coincident with Ld_A: shift the freshly loaded value
    Ld_A = 1'b1; D = 8'h80;
    start(2'b01, 1'b0, 1);
    Ld_A = 1'b0;
    chk("coinc_loaded_A", A, 8'h80);
    wait_idle_busy(n);
    check_result("coinc_asr1", n, 1, 8'hC0, 8'h1E);

    // Asynchronous reset during the 2nd Busy cycle of an LSR count 8
    load(8'h96, 8'h3C);
    start(2'b00, 1'b0, 8);
    step();
    chk("rst_mid_busy_before", Busy, 1'b1);
    Reset = 1'b1;
    #1;
    chk("rst_mid_A", A, 8'h00);
    chk("rst_mid_B", B, 8'h00);
    chk("rst_mid_Busy", Busy, 1'b0);
    chk("rst_mid_Done", Done, 1'b0);
    step();
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_mid_no_done", Done, 1'b0);
    end
    chk("rst_mid_idle_busy", Busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
